id_ctrl_stage: RTL and testbench

Registered RV32I decode stage for the pipelined CPU. Decodes the instruction presented by IF/ID and captures the full control bundle into the ID/EX register with valid/ready flow control. Inserts load-use bubbles and enforces multi-cycle mul/div issue spacing. Flags illegal encodings, and optionally decodes the RV32M extension.

---
 rtl/id_ctrl_stage.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_id_ctrl_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: registered RV32I decode stage sitting between IF/ID and ID/EX.
//
// Decodes the IF/ID instruction into the EX control bundle and captures it with
// valid/ready flow control. Inserts load-use bubbles, spaces back-to-back
// mul/div issues, and flags illegal encodings (sticky illegal_seen).
//
// Build option: define IDSTAGE_MEXT_EN to decode RV32M (funct7=0000001) and
// enable the mul/div busy counter. Without it those encodings are illegal and
// MULDIV_LAT has no effect.
//
// Ports:
//   clk, rstn              clock (rising edge), async active-low reset
//   id_valid / id_ready    IF/ID handshake (id_ready is combinational)
//   instr                  instruction word from IF/ID
//   flush                  EX redirect, kills the ID instruction
//   ex_ready / ex_valid    ID/EX handshake
//   ex_ld, ex_ld_rd        load currently in EX, for load-use detection
//   ex_*                   registered control bundle and register fields
//   ex_illegal             registered bundle is an illegal encoding
//   illegal_seen           sticky, set by any issued illegal instruction
module id_ctrl_stage #(
    parameter int ALUOP_W    = 5,
    parameter int MULDIV_LAT = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [31:0]        instr,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    input  logic [4:0]         ex_ld_rd,
    input  logic               ex_ld,
    output logic               ex_RegWrite,
    output logic               ex_MemWrite,
    output logic               ex_MemRead,
    output logic               ex_ALUSrc,
    output logic [5:0]         ex_EXTOp,
    output logic [ALUOP_W-1:0] ex_ALUOp,
    output logic [2:0]         ex_NPCOp,
    output logic [1:0]         ex_WDSel,
    output logic [2:0]         ex_dm_ctrl,
    output logic [4:0]         ex_rd,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic               ex_illegal,
    output logic               illegal_seen
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AUIPC= ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_BNE  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_BLT  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_BGE  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_BLTU = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_BGEU = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(14);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(15);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(16);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(17);

    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;

    typedef struct packed {
        logic               reg_write;
        logic               mem_write;
        logic               mem_read;
        logic               alu_src;
        logic [5:0]         ext_op;
        logic [ALUOP_W-1:0] alu_op;
        logic [2:0]         npc_op;
        logic [1:0]         wd_sel;
        logic [2:0]         dm_ctrl;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic               illegal;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // ALU op for the funct7=0000000 register ops; shared with the immediate
    // forms, whose shift encodings are handled separately.
    function automatic logic [ALUOP_W-1:0] alu_of_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    bundle_t dec;
    bundle_t bundle_q;
    logic    use_rs1;
    logic    use_rs2;
    logic    is_muldiv;
    logic    legal;

    always_comb begin
        dec       = '0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_muldiv = 1'b0;
        legal     = 1'b1;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                case (funct7)
                    7'b0000000: dec.alu_op = alu_of_f3(funct3);
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec.alu_op = ALU_SUB;
                        else if (funct3 == 3'b101) dec.alu_op = ALU_SRA;
                        else                       legal = 1'b0;
                    end
`ifdef IDSTAGE_MEXT_EN
                    7'b0000001: begin
                        // mul..remu are consecutive codes in funct3 order
                        dec.alu_op = ALUOP_W'(18) + ALUOP_W'(funct3);
                        is_muldiv  = 1'b1;
                    end
`endif
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                use_rs1       = 1'b1;
                dec.ext_op    = EXT_I;
                dec.alu_op    = alu_of_f3(funct3);
                if (funct3 == 3'b001) begin
                    dec.ext_op = EXT_SHAMT;
                    legal      = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec.ext_op = EXT_SHAMT;
                    if (funct7 == 7'b0100000)      dec.alu_op = ALU_SRA;
                    else if (funct7 != 7'b0000000) legal = 1'b0;
                end
            end
            OP_LOAD: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_I;
                dec.alu_op    = ALU_ADD;
                dec.wd_sel    = 2'b01;
                use_rs1       = 1'b1;
                case (funct3)
                    3'b000:  dec.dm_ctrl = 3'b011;
                    3'b001:  dec.dm_ctrl = 3'b001;
                    3'b010:  dec.dm_ctrl = 3'b000;
                    3'b100:  dec.dm_ctrl = 3'b100;
                    3'b101:  dec.dm_ctrl = 3'b010;
                    default: legal = 1'b0;
                endcase
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_S;
                dec.alu_op    = ALU_ADD;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                case (funct3)
                    3'b000:  dec.dm_ctrl = 3'b011;
                    3'b001:  dec.dm_ctrl = 3'b001;
                    3'b010:  dec.dm_ctrl = 3'b000;
                    default: legal = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                dec.npc_op = 3'b001;
                dec.ext_op = EXT_B;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_SUB;
                    3'b001:  dec.alu_op = ALU_BNE;
                    3'b100:  dec.alu_op = ALU_BLT;
                    3'b101:  dec.alu_op = ALU_BGE;
                    3'b110:  dec.alu_op = ALU_BLTU;
                    3'b111:  dec.alu_op = ALU_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.npc_op    = 3'b010;
                dec.wd_sel    = 2'b10;
                dec.ext_op    = EXT_J;
            end
            OP_JALR: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.npc_op    = 3'b100;
                dec.wd_sel    = 2'b10;
                dec.ext_op    = EXT_I;
                use_rs1       = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_U;
                dec.alu_op    = (opcode == OP_LUI) ? ALU_LUI : ALU_AUIPC;
            end
            default: legal = 1'b0;
        endcase

        // Register fields follow the format; only rd is written by J/U/I/R.
        dec.rd  = (dec.reg_write) ? instr[11:7]  : 5'd0;
        dec.rs1 = (use_rs1)       ? instr[19:15] : 5'd0;
        dec.rs2 = (use_rs2)       ? instr[24:20] : 5'd0;

        // An illegal word issues as an inert bundle that reads no registers.
        if (!legal) begin
            dec         = '0;
            dec.alu_op  = ALU_NOP;
            dec.illegal = 1'b1;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
            is_muldiv   = 1'b0;
        end
    end

    logic hz;
    logic busy;
    logic adv;
    logic issue;

    assign hz = ex_ld & (ex_ld_rd != 5'd0) &
                ((use_rs1 & (instr[19:15] == ex_ld_rd)) |
                 (use_rs2 & (instr[24:20] == ex_ld_rd)));

`ifdef IDSTAGE_MEXT_EN
    localparam logic [3:0] BCNT_LOAD = 4'(MULDIV_LAT - 1);

    logic [3:0] bcnt;

    // flush kills issue, so a flushed mul/div never reloads the counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bcnt <= 4'd0;
        end else if (issue && is_muldiv) begin
            bcnt <= BCNT_LOAD;
        end else if (bcnt != 4'd0) begin
            bcnt <= bcnt - 4'd1;
        end
    end

    assign busy = (bcnt != 4'd0) & is_muldiv;
`else
    logic unused_muldiv;
    assign unused_muldiv = (MULDIV_LAT != 0) | is_muldiv;
    assign busy          = 1'b0;
`endif

    assign adv      = ex_ready | ~ex_valid;
    assign id_ready = adv & ~hz & ~busy;
    assign issue    = id_valid & id_ready & ~flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid     <= 1'b0;
            bundle_q     <= '0;
            illegal_seen <= 1'b0;
        end else begin
            if (flush) begin
                ex_valid <= 1'b0;
                bundle_q <= '0;
            end else if (issue) begin
                ex_valid <= 1'b1;
                bundle_q <= dec;
            end else if (adv) begin
                ex_valid <= 1'b0;
                bundle_q <= '0;
            end
            if (issue && dec.illegal) begin
                illegal_seen <= 1'b1;
            end
        end
    end

    assign ex_RegWrite = bundle_q.reg_write;
    assign ex_MemWrite = bundle_q.mem_write;
    assign ex_MemRead  = bundle_q.mem_read;
    assign ex_ALUSrc   = bundle_q.alu_src;
    assign ex_EXTOp    = bundle_q.ext_op;
    assign ex_ALUOp    = bundle_q.alu_op;
    assign ex_NPCOp    = bundle_q.npc_op;
    assign ex_WDSel    = bundle_q.wd_sel;
    assign ex_dm_ctrl  = bundle_q.dm_ctrl;
    assign ex_rd       = bundle_q.rd;
    assign ex_rs1      = bundle_q.rs1;
    assign ex_rs2      = bundle_q.rs2;
    assign ex_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Testbench for id_ctrl_stage: directed scenarios plus a randomized run checked
// against a mask/match instruction table and a cycle-count spacing model.
module tb_id_ctrl_stage;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] instr;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [4:0]  ex_ld_rd;
    logic        ex_ld;
    logic        ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc;
    logic [5:0]  ex_EXTOp;
    logic [4:0]  ex_ALUOp;
    logic [2:0]  ex_NPCOp;
    logic [1:0]  ex_WDSel;
    logic [2:0]  ex_dm_ctrl;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic        ex_illegal;
    logic        illegal_seen;

    int total = 0;
    int bad   = 0;

    id_ctrl_stage #(.ALUOP_W(5), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_ready(id_ready),
        .instr(instr), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_ld_rd(ex_ld_rd), .ex_ld(ex_ld), .ex_RegWrite(ex_RegWrite),
        .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead), .ex_ALUSrc(ex_ALUSrc),
        .ex_EXTOp(ex_EXTOp), .ex_ALUOp(ex_ALUOp), .ex_NPCOp(ex_NPCOp),
        .ex_WDSel(ex_WDSel), .ex_dm_ctrl(ex_dm_ctrl), .ex_rd(ex_rd),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_illegal(ex_illegal),
        .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    logic [40:0] obs;
    assign obs = {ex_valid, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc, ex_EXTOp,
                  ex_ALUOp, ex_NPCOp, ex_WDSel, ex_dm_ctrl, ex_rd, ex_rs1, ex_rs2,
                  ex_illegal, illegal_seen};

    localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_ADDH = 32'h00728333; // add x6,x5,x7
    localparam logic [31:0] I_ADD0 = 32'h00700333; // add x6,x0,x7
    localparam logic [31:0] I_SW   = 32'h0020A023; // sw x2,0(x1)
    localparam logic [31:0] I_JAL  = 32'h008000EF; // jal x1,8
    localparam logic [31:0] I_ILL  = 32'h0000707F;
    localparam logic [31:0] I_DIV  = 32'h0220C1B3; // div x3,x1,x2
    localparam logic [31:0] I_MUL  = 32'h02208233; // mul x4,x1,x2

`ifdef IDSTAGE_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    // ---------------- reference instruction table ----------------
    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
        logic [4:0]  alu;
        logic [3:0]  ctl;   // RegWrite, MemWrite, MemRead, ALUSrc
        logic [5:0]  ext;
        logic [2:0]  npc;
        logic [1:0]  wd;
        logic [2:0]  dm;
        logic [3:0]  use_; // rd, rs1, rs2, muldiv
    } ent_t;

    ent_t tbl[$];

    function automatic ent_t mk(input logic [31:0] mask, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] alu, input logic [3:0] ctl,
                                input logic [5:0] ext, input logic [2:0] npc,
                                input logic [1:0] wd, input logic [2:0] dm,
                                input logic [3:0] u);
        ent_t e;
        e.mask  = mask;
        e.match = ({f7, 18'd0, 7'd0} | {17'd0, f3, 12'd0} | {25'd0, op}) & mask;
        e.alu = alu; e.ctl = ctl; e.ext = ext; e.npc = npc; e.wd = wd; e.dm = dm;
        e.use_ = u;
        return e;
    endfunction

    task automatic build_table();
        int ralu [8] = '{3, 15, 10, 11, 12, 16, 13, 14};
        int ldm  [8] = '{3, 1, 0, -1, 4, 2, -1, -1};
        int balu [8] = '{4, 5, -1, -1, 6, 7, 8, 9};
        for (int f = 0; f < 8; f++) begin
            tbl.push_back(mk(32'hFE00707F, 7'h33, 3'(f), 7'h00, 5'(ralu[f]), 4'b1000,
                             6'd0, 3'd0, 2'd0, 3'd0, 4'b1110));
            if (MEXT)
                tbl.push_back(mk(32'hFE00707F, 7'h33, 3'(f), 7'h01, 5'(18 + f), 4'b1000,
                                 6'd0, 3'd0, 2'd0, 3'd0, 4'b1111));
            if (f != 1 && f != 5)
                tbl.push_back(mk(32'h0000707F, 7'h13, 3'(f), 7'h00, 5'(ralu[f]), 4'b1001,
                                 6'b010000, 3'd0, 2'd0, 3'd0, 4'b1100));
            if (ldm[f] >= 0)
                tbl.push_back(mk(32'h0000707F, 7'h03, 3'(f), 7'h00, 5'd3, 4'b1011,
                                 6'b010000, 3'd0, 2'b01, 3'(ldm[f]), 4'b1100));
            if (f <= 2)
                tbl.push_back(mk(32'h0000707F, 7'h23, 3'(f), 7'h00, 5'd3, 4'b0101,
                                 6'b001000, 3'd0, 2'd0, 3'(ldm[f]), 4'b0110));
            if (balu[f] >= 0)
                tbl.push_back(mk(32'h0000707F, 7'h63, 3'(f), 7'h00, 5'(balu[f]), 4'b0000,
                                 6'b000100, 3'b001, 2'd0, 3'd0, 4'b0110));
        end
        tbl.push_back(mk(32'hFE00707F, 7'h33, 3'd0, 7'h20, 5'd4, 4'b1000, 6'd0, 3'd0, 2'd0, 3'd0, 4'b1110));
        tbl.push_back(mk(32'hFE00707F, 7'h33, 3'd5, 7'h20, 5'd17, 4'b1000, 6'd0, 3'd0, 2'd0, 3'd0, 4'b1110));
        tbl.push_back(mk(32'hFE00707F, 7'h13, 3'd1, 7'h00, 5'd15, 4'b1001, 6'b100000, 3'd0, 2'd0, 3'd0, 4'b1100));
        tbl.push_back(mk(32'hFE00707F, 7'h13, 3'd5, 7'h00, 5'd16, 4'b1001, 6'b100000, 3'd0, 2'd0, 3'd0, 4'b1100));
        tbl.push_back(mk(32'hFE00707F, 7'h13, 3'd5, 7'h20, 5'd17, 4'b1001, 6'b100000, 3'd0, 2'd0, 3'd0, 4'b1100));
        tbl.push_back(mk(32'h0000007F, 7'h6F, 3'd0, 7'h00, 5'd0, 4'b1000, 6'b000001, 3'b010, 2'b10, 3'd0, 4'b1000));
        tbl.push_back(mk(32'h0000007F, 7'h67, 3'd0, 7'h00, 5'd3, 4'b1001, 6'b010000, 3'b100, 2'b10, 3'd0, 4'b1100));
        tbl.push_back(mk(32'h0000007F, 7'h37, 3'd0, 7'h00, 5'd1, 4'b1001, 6'b000010, 3'd0, 2'd0, 3'd0, 4'b1000));
        tbl.push_back(mk(32'h0000007F, 7'h17, 3'd0, 7'h00, 5'd2, 4'b1001, 6'b000010, 3'd0, 2'd0, 3'd0, 4'b1000));
    endtask

    function automatic int lookup(input logic [31:0] w);
        for (int k = 0; k < tbl.size(); k++)
            if ((w & tbl[k].mask) == tbl[k].match) return k;
        return -1;
    endfunction

    // Bundle without valid/seen: 39 bits in output order.
    function automatic logic [38:0] ref_bundle(input logic [31:0] w);
        int   k;
        ent_t e;
        k = lookup(w);
        if (k < 0) return 39'd1;
        e = tbl[k];
        return {e.ctl, e.ext, e.alu, e.npc, e.wd, e.dm,
                e.use_[3] ? w[11:7] : 5'd0, e.use_[2] ? w[19:15] : 5'd0,
                e.use_[1] ? w[24:20] : 5'd0, 1'b0};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [31:0] w, input logic f,
                         input logic er, input logic ld, input logic [4:0] ldrd);
        @(negedge clk);
        id_valid = v; instr = w; flush = f; ex_ready = er; ex_ld = ld; ex_ld_rd = ldrd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        id_valid = 1'b0; instr = 32'd0; flush = 1'b0; ex_ready = 1'b1;
        ex_ld = 1'b0; ex_ld_rd = 5'd0;
        #2;
        rstn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        drive(1, I_ILL, 0, 1, 0, 0); tick();
        drive(1, I_SW, 0, 1, 0, 0);  tick();
        drive(1, I_ADD, 0, 0, 0, 0);
        total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL pre_reset_stall id_ready got %b want 0", id_ready); end
        rstn = 1'b0;
        #1;
        total++; if (obs !== 41'd0) begin bad++; $display("FAIL reset_outputs got %h want 0", obs); end
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_id_ready got %b want 1", id_ready); end
        rstn = 1'b1;
        ex_ready = 1'b1;
        tick();
        total++;
        if ({ex_valid, ex_ALUOp, ex_RegWrite, ex_rd} !== {1'b1, 5'd3, 1'b1, 5'd3}) begin
            bad++; $display("FAIL reset_then_add got v=%b alu=%0d rw=%b rd=%0d want 1/3/1/3",
                            ex_valid, ex_ALUOp, ex_RegWrite, ex_rd);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, I_ADD, 0, 1, 0, 0); tick();
        drive(1, I_ADDH, 0, 1, 1, 5'd5);
        total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL ldu_stall id_ready got %b want 0", id_ready); end
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL ldu_bubble ex_valid got %b want 0", ex_valid); end
        drive(1, I_ADDH, 0, 1, 0, 5'd5);
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL ldu_release id_ready got %b want 1", id_ready); end
        tick();
        total++;
        if ({ex_valid, ex_ALUOp, ex_rd, ex_rs1, ex_rs2} !== {1'b1, 5'd3, 5'd6, 5'd5, 5'd7}) begin
            bad++; $display("FAIL ldu_issue got v=%b alu=%0d rd=%0d rs1=%0d rs2=%0d want 1/3/6/5/7",
                            ex_valid, ex_ALUOp, ex_rd, ex_rs1, ex_rs2);
        end
        drive(1, I_ADD0, 0, 1, 1, 5'd0);
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL ldu_x0 id_ready got %b want 1", id_ready); end
        drive(1, I_ADD0, 0, 1, 1, 5'd7);
        total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL ldu_rs2 id_ready got %b want 0", id_ready); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1, I_SW, 0, 1, 0, 0); tick();
        for (int c = 0; c < 3; c++) begin
            drive(1, I_ADD, 0, 0, 0, 0);
            total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL bp_id_ready[%0d] got %b want 0", c, id_ready); end
            tick();
            total++;
            if ({ex_valid, ex_MemWrite, ex_RegWrite, ex_EXTOp, ex_dm_ctrl, ex_rs1, ex_rs2}
                !== {1'b1, 1'b1, 1'b0, 6'b001000, 3'b000, 5'd1, 5'd2}) begin
                bad++; $display("FAIL bp_hold[%0d] got v=%b mw=%b rw=%b ext=%b dm=%b rs1=%0d rs2=%0d", c,
                                ex_valid, ex_MemWrite, ex_RegWrite, ex_EXTOp, ex_dm_ctrl, ex_rs1, ex_rs2);
            end
        end
        drive(1, I_ADD, 0, 1, 0, 0); tick();
        total++; if ({ex_valid, ex_ALUOp} !== {1'b1, 5'd3}) begin bad++; $display("FAIL bp_resume got v=%b alu=%0d want 1/3", ex_valid, ex_ALUOp); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, I_ADD, 0, 1, 0, 0); tick();
        drive(1, I_JAL, 1, 1, 0, 0); tick();
        total++; if ({ex_valid, ex_NPCOp, ex_RegWrite} !== 5'b0) begin bad++; $display("FAIL flush_jal got v=%b npc=%b rw=%b want 0", ex_valid, ex_NPCOp, ex_RegWrite); end
        drive(1, I_JAL, 0, 1, 0, 0); tick();
        total++;
        if ({ex_valid, ex_NPCOp, ex_WDSel, ex_EXTOp, ex_rd} !== {1'b1, 3'b010, 2'b10, 6'b000001, 5'd1}) begin
            bad++; $display("FAIL jal_issue got v=%b npc=%b wd=%b ext=%b rd=%0d", ex_valid, ex_NPCOp, ex_WDSel, ex_EXTOp, ex_rd);
        end
        if (MEXT) begin
            drive(1, I_DIV, 1, 1, 0, 0); tick();
            drive(1, I_DIV, 0, 1, 0, 0);
            total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL flush_no_bcnt id_ready got %b want 1", id_ready); end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1, I_ILL, 0, 1, 0, 0); tick();
        total++;
        if ({ex_valid, ex_illegal, ex_RegWrite, ex_MemWrite, ex_MemRead, ex_NPCOp, ex_ALUOp, illegal_seen}
            !== {1'b1, 1'b1, 6'd0, 5'd0, 1'b1}) begin
            bad++; $display("FAIL illegal_issue got %h", obs);
        end
        for (int c = 0; c < 3; c++) begin
            drive(1, I_ADD, 0, 1, 0, 0); tick();
            total++; if ({ex_illegal, illegal_seen} !== 2'b01) begin bad++; $display("FAIL illegal_sticky[%0d] got ill=%b seen=%b want 0/1", c, ex_illegal, illegal_seen); end
        end
        do_reset();
        total++; if (illegal_seen !== 1'b0) begin bad++; $display("FAIL illegal_clear got %b want 0", illegal_seen); end
    endtask

    task automatic test_mext();
        int k;
        do_reset();
        if (!MEXT) begin
            drive(1, I_DIV, 0, 1, 0, 0); tick();
            total++; if ({ex_valid, ex_illegal, ex_RegWrite, ex_ALUOp} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin bad++; $display("FAIL div_illegal got %h", obs); end
            return;
        end
        drive(1, I_DIV, 0, 1, 0, 0); tick();
        total++; if ({ex_valid, ex_ALUOp, ex_RegWrite, ex_ALUSrc, ex_WDSel} !== {1'b1, 5'd22, 1'b1, 1'b0, 2'b00}) begin bad++; $display("FAIL div_issue got %h", obs); end
        drive(1, I_ADD, 0, 1, 0, 0); tick();
        total++; if ({ex_valid, ex_ALUOp} !== {1'b1, 5'd3}) begin bad++; $display("FAIL add_between got v=%b alu=%0d want 1/3", ex_valid, ex_ALUOp); end
        for (int c = 2; c < 4; c++) begin
            drive(1, I_MUL, 0, 1, 0, 0);
            total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL mul_spacing t+%0d id_ready got %b want 0", c, id_ready); end
            tick();
        end
        drive(1, I_MUL, 0, 1, 0, 0);
        total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL mul_t4 id_ready got %b want 1", id_ready); end
        tick();
        total++; if ({ex_valid, ex_ALUOp} !== {1'b1, 5'd18}) begin bad++; $display("FAIL mul_issue got v=%b alu=%0d want 1/18", ex_valid, ex_ALUOp); end
        for (int c = 0; c < 4; c++) begin drive(0, 0, 0, 1, 0, 0); tick(); end
        drive(1, I_DIV, 0, 1, 0, 0); tick();
        drive(1, I_MUL, 0, 1, 0, 0);
        k = 11;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (ex_valid && ex_ALUOp == 5'd18) begin k = c; break; end
        end
        total++; if (k !== LAT) begin bad++; $display("FAIL b2b_spacing got %0d want %0d", k, LAT); end
        drive(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        logic        m_valid, m_seen, m_hz, m_busy, m_adv, m_rdy, m_issue;
        logic [38:0] m_bundle;
        int          k, cyc, last_md;
        do_reset();
        m_valid = 0; m_seen = 0; m_bundle = '0; cyc = 0; last_md = -1000;
        for (int c = 0; c < 600; c++) begin
            logic [31:0] w;
            w = $urandom;
            case ($urandom_range(0, 10))
                0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
                3: w[6:0] = 7'h23;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;
                6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;  8: w[6:0] = 7'h17;
                9: w[6:0] = 7'h33;  default: ;
            endcase
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;  1: w[31:25] = 7'h20;  2: w[31:25] = 7'h01;  default: ;
            endcase
            drive($urandom_range(0, 9) < 8, w, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)));
            k      = lookup(instr);
            m_hz   = ex_ld && ex_ld_rd != 0 && k >= 0 &&
                     ((tbl[k].use_[2] && instr[19:15] == ex_ld_rd) ||
                      (tbl[k].use_[1] && instr[24:20] == ex_ld_rd));
            m_busy = k >= 0 && tbl[k].use_[0] && (cyc - last_md < LAT);
            m_adv  = ex_ready || !m_valid;
            m_rdy  = m_adv && !m_hz && !m_busy;
            total++; if (id_ready !== m_rdy) begin bad++; $display("FAIL rnd_id_ready cyc=%0d instr=%h got %b want %b", cyc, instr, id_ready, m_rdy); end
            m_issue = id_valid && m_rdy && !flush;
            if (flush || (!m_issue && m_adv)) begin
                m_valid = 0; m_bundle = '0;
            end else if (m_issue) begin
                m_valid = 1; m_bundle = ref_bundle(instr);
                if (k < 0) m_seen = 1;
                else if (tbl[k].use_[0]) last_md = cyc;
            end
            tick();
            cyc++;
            total++; if (obs !== {m_valid, m_bundle, m_seen}) begin bad++; $display("FAIL rnd_bundle cyc=%0d instr=%h got %h want %h", cyc, instr, obs, {m_valid, m_bundle, m_seen}); end
        end
    endtask

    initial begin
        rstn = 1'b0;
        id_valid = 1'b0; instr = 32'd0; flush = 1'b0; ex_ready = 1'b1;
        ex_ld = 1'b0; ex_ld_rd = 5'd0;
        build_table();
        #12 rstn = 1'b1;
        test_reset();
        test_load_use();
        test_backpressure();
        test_flush();
        test_illegal();
        test_mext();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
